// File: rtl/serial_adder_if.sv
// Operand/result/handshake bundle for the bit-serial adder/subtractor.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, a, b, cin,
        input  sum, carry, overflow, busy, done
    );

    modport slave (
        input  start, sub, a, b, cin,
        output sum, carry, overflow, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per operation, framed by a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s_bit;
    logic             c_out;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        s_bit  = a_q[0] ^ b_q[0] ^ c_q;
        c_out  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        r_next = {s_bit, r_q[WIDTH-1:1]};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtract as a + ~b + 1: invert B and seed the carry with cin ^ sub.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d   = c_out;
                r_d   = r_next;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // c_q is still the carry into the MSB on this last bit.
                    sum_d   = r_next;
                    carry_d = c_out;
                    ovf_d   = c_q ^ c_out;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8 (directed), 16 and 2 (random):
// expectations are queued when a start is accepted and checked at each done.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  b8 ();
    serial_adder_if #(.WIDTH(16)) b16 ();
    serial_adder_if #(.WIDTH(2))  b2 ();

    serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
    serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic [31:0] t0;
    } exp_t;

    exp_t        sb_q [3][$];
    logic [31:0] last_sum [3];
    logic [31:0] cyc = 0;
    logic        rst_d = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx(int w);
        return (w == 8) ? 0 : ((w == 16) ? 1 : 2);
    endfunction

    function automatic exp_t mk(logic [31:0] s, logic c, logic o);
        exp_t e;
        e.sum = s; e.carry = c; e.ovf = o; e.t0 = '0;
        return e;
    endfunction

    // Behavioural reference: a + (sub ? ~b : b) + (cin ^ sub), mod 2^w.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sb);
        logic [32:0] mask, aa, bb, full;
        exp_t e;
        mask   = (33'd1 << w) - 33'd1;
        aa     = {1'b0, a} & mask;
        bb     = sb ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full   = aa + bb + 33'(ci ^ sb);
        e.sum  = full[31:0] & mask[31:0];
        e.carry = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.t0   = '0;
        return e;
    endfunction

    task automatic read_out(int w, output logic [31:0] s, output logic c, output logic o,
                            output logic bz, output logic dn);
        case (w)
            8:  begin s = 32'(b8.sum);  c = b8.carry;  o = b8.overflow;  bz = b8.busy;  dn = b8.done;  end
            16: begin s = 32'(b16.sum); c = b16.carry; o = b16.overflow; bz = b16.busy; dn = b16.done; end
            default: begin s = 32'(b2.sum); c = b2.carry; o = b2.overflow; bz = b2.busy; dn = b2.done; end
        endcase
    endtask

    task automatic drive(int w, logic st, logic sb, logic [31:0] a, logic [31:0] b, logic ci);
        case (w)
            8:  begin b8.start = st;  b8.sub = sb;  b8.a = a[7:0];   b8.b = b[7:0];   b8.cin = ci;  end
            16: begin b16.start = st; b16.sub = sb; b16.a = a[15:0]; b16.b = b[15:0]; b16.cin = ci; end
            default: begin b2.start = st; b2.sub = sb; b2.a = a[1:0]; b2.b = b[1:0]; b2.cin = ci; end
        endcase
    endtask

    // Called at a negedge; queues the expectation only if the DUT is idle and not in reset.
    task automatic start_op(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sb, exp_t e);
        logic [31:0] s;
        logic c, o, bz, dn;
        read_out(w, s, c, o, bz, dn);
        drive(w, 1'b1, sb, a, b, ci);
        if (bz !== 1'b1 && rst !== 1'b1) begin
            e.t0 = cyc;
            sb_q[idx(w)].push_back(e);
        end
        @(negedge clk);
        drive(w, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_done(int w);
        logic [31:0] s;
        logic c, o, bz, dn;
        bit seen = 1'b0;
        for (int k = 0; k < w + 4 && !seen; k++) begin
            read_out(w, s, c, o, bz, dn);
            if (dn === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check($sformatf("done_timeout_w%0d", w), 32'd0, 32'd1);
    endtask

    task automatic mon(int w);
        logic [31:0] s;
        logic c, o, bz, dn;
        exp_t e;
        int i;
        i = idx(w);
        read_out(w, s, c, o, bz, dn);
        if (rst_d) begin
            last_sum[i] = '0;
            return;
        end
        if (bz === 1'b1) check($sformatf("hold_w%0d", w), s, last_sum[i]);
        if (dn === 1'b1) begin
            if (sb_q[i].size() == 0) begin
                check($sformatf("spurious_done_w%0d", w), 32'd1, 32'd0);
            end else begin
                e = sb_q[i].pop_front();
                check($sformatf("sum_w%0d", w), s, e.sum);
                check($sformatf("carry_w%0d", w), 32'(c), 32'(e.carry));
                check($sformatf("ovf_w%0d", w), 32'(o), 32'(e.ovf));
                check($sformatf("latency_w%0d", w), cyc - e.t0, 32'(w + 1));
                last_sum[i] = e.sum;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(8);
        mon(16);
        mon(2);
    end

    task automatic check_reset_state(string tag);
        logic [31:0] s;
        logic c, o, bz, dn;
        read_out(8, s, c, o, bz, dn);
        check({tag, "_sum"}, s, 32'd0);
        check({tag, "_carry"}, 32'(c), 32'd0);
        check({tag, "_ovf"}, 32'(o), 32'd0);
        check({tag, "_busy"}, 32'(bz), 32'd0);
        check({tag, "_done"}, 32'(dn), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic c, o, bz, dn;
        drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(16, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(2, 1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        start_op(8, 32'd200, 32'd100, 1'b0, 1'b0, mk(32'h2C, 1'b1, 1'b0));
        wait_done(8);
        @(negedge clk);
        start_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1));
        wait_done(8);
        // issued in the done cycle: must be accepted
        start_op(8, 32'h80, 32'h01, 1'b0, 1'b1, mk(32'h7F, 1'b1, 1'b1));
        read_out(8, s, c, o, bz, dn);
        check("busy_reassert", 32'(bz), 32'd1);
        wait_done(8);
        start_op(8, 32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFE, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) begin
            drive(8, 1'b1, 1'b0, 32'hFF, 32'hFF, 1'b1);
            @(negedge clk);
        end
        drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
        wait_done(8);
        start_op(8, 32'd10, 32'd3, 1'b1, 1'b1, mk(32'h06, 1'b1, 1'b0));
        wait_done(8);
        @(negedge clk);

        // abort mid-run, with a start presented in the reset cycle
        start_op(8, 32'h55, 32'h22, 1'b0, 1'b0, mk(32'h77, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(8, 1'b1, 1'b0, 32'h11, 32'h11, 1'b0);
        sb_q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        drive(8, 1'b0, 1'b0, '0, '0, 1'b0);
        check_reset_state("midrst");
        repeat (12) @(negedge clk);
        read_out(8, s, c, o, bz, dn);
        check("idle_after_rst", 32'(bz), 32'd0);
        start_op(8, 32'h55, 32'h22, 1'b0, 1'b0, mk(32'h77, 1'b0, 1'b0));
        wait_done(8);
        @(negedge clk);

        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 16 : 2;
            for (int n = 0; n < 1000; n++) begin
                logic [31:0] ra, rb;
                logic rc, rs;
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                start_op(w, ra, rb, rc, rs, model(w, ra, rb, rc, rs));
                wait_done(w);
            end
            repeat (2) @(negedge clk);
        end

        check("sb_empty_w8", 32'(sb_q[0].size()), 32'd0);
        check("sb_empty_w16", 32'(sb_q[1].size()), 32'd0);
        check("sb_empty_w2", 32'(sb_q[2].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
